gate_count_controller: RTL and testbench

Parametrised gate-and-count controller for the frequency-meter datapath. Sequences the clear / count / save / display phases from a timebase tick input, with a programmable gate length and display hold. Integrates the event counter with saturation and overflow flag. Supports continuous and single-shot operation.

---
 rtl/gate_count_controller.sv | 133 +++++++++++++
 tb/tb_gate_count_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_count_controller.sv
// Gate-and-count controller: tick-driven clear/count/save/display sequencing with saturating event counter.
// Optional macro SIG_SYNC_EN inserts a two-flop synchroniser on sig ahead of edge detection.
module gate_count_controller #(
  parameter int CNT_W      = 16,
  parameter int GATE_TICKS = 1,
  parameter int DISP_TICKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             sig,
  input  logic             single,
  input  logic             start,
  output logic             clr,
  output logic             count,
  output logic             save,
  output logic             disp,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);
  localparam int MAX_TICKS = (GATE_TICKS > DISP_TICKS) ? GATE_TICKS : DISP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TICKS - 1);
  localparam logic [TW-1:0] DISP_LAST = TW'(DISP_TICKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_SAVE  = 3'd4;
  localparam logic [2:0] S_DISP  = 3'd5;

  logic [2:0]       state, state_d;
  logic [TW-1:0]    tick_cnt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic             in_q, sig_s, sig_q;
  logic             tick, sig_edge;

`ifdef SIG_SYNC_EN
  logic sig_m1, sig_m2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_m1 <= 1'b0;
      sig_m2 <= 1'b0;
    end else begin
      sig_m1 <= sig;
      sig_m2 <= sig_m1;
    end
  end
  assign sig_s = sig_m2;
`else
  assign sig_s = sig;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q  <= 1'b0;
      sig_q <= 1'b0;
    end else begin
      in_q  <= in;
      sig_q <= sig_s;
    end
  end

  assign tick     = in & ~in_q;
  assign sig_edge = sig_s & ~sig_q;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (!single || start) state_d = S_CLR;
      S_CLR:   state_d = S_WAIT;
      S_WAIT:  if (tick) state_d = S_COUNT;
      S_COUNT: if (tick && tick_cnt == GATE_LAST) state_d = S_SAVE;
      S_SAVE:  state_d = S_DISP;
      S_DISP:  if (tick && tick_cnt == DISP_LAST) state_d = single ? S_IDLE : S_CLR;
      default: state_d = S_IDLE;
    endcase
  end

  // WAIT and SAVE both precede a tick-counted phase, so the counter is parked at zero there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_WAIT, S_SAVE:  tick_cnt <= '0;
        S_COUNT, S_DISP: if (tick) tick_cnt <= tick_cnt + TW'(1);
        default:         ;
      endcase
    end
  end

  // An edge arriving while the counter is already all-ones is lost and marks the gate as overflowed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else if (state == S_CLR) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else if (state == S_COUNT && sig_edge) begin
      if (&cnt) cnt_ovf <= 1'b1;
      else      cnt     <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= (state == S_SAVE);
      if (state == S_SAVE) begin
        result <= cnt;
        ovf    <= cnt_ovf;
      end
    end
  end

  assign clr   = (state == S_CLR);
  assign count = (state == S_COUNT);
  assign save  = (state == S_SAVE);
  assign disp  = (state == S_DISP);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_gate_count_controller.sv
// Bench for gate_count_controller: per-segment stimulus tables, an interval-based reference
// schedule (tick search + edge counting per gate), and per-cycle comparison of all outputs.
module tb_gate_count_controller;
  localparam int CNT_W = 4;
  localparam int GT    = 2;
  localparam int DT    = 1;
  localparam int N     = 400;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int P_IDLE = 0, P_CLR = 1, P_WAIT = 2, P_CNT = 3, P_SAVE = 4, P_DISP = 5;

  logic clk = 1'b0, reset = 1'b0, in = 1'b0, sig = 1'b0, single = 1'b0, start = 1'b0;
  logic clr, count, save, disp, busy, valid, ovf;
  logic [CNT_W-1:0] result;

  gate_count_controller #(.CNT_W(CNT_W), .GATE_TICKS(GT), .DISP_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .in(in), .sig(sig), .single(single), .start(start),
    .clr(clr), .count(count), .save(save), .disp(disp), .busy(busy), .valid(valid),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       in_a[N], sig_a[N], sgl_a[N], st_a[N];
  logic [5:0] e_ph[N];   // {clr,count,save,disp,busy,valid}
  int         e_res[N];
  logic       e_ovf[N];
  logic [5:0] o_ph[N];
  int         o_res[N];
  logic       o_ovf[N];
  int         cur_res;
  logic       cur_ovf;

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic tk(int c);
    return in_a[c] && !(c > 0 && in_a[c-1]);
  endfunction

  function automatic logic ev(int c);
    int r = c - LAT;
    if (r < 0) return 1'b0;
    return sig_a[r] && !(r > 0 && sig_a[r-1]);
  endfunction

  function automatic int next_tick(int from);
    for (int c = from; c < N; c++) if (tk(c)) return c;
    return N;
  endfunction

  task automatic mark(int c, int ph, logic v);
    if (c < 0 || c >= N) return;
    case (ph)
      P_IDLE:  e_ph[c] = 6'b000000;
      P_CLR:   e_ph[c] = 6'b100010;
      P_WAIT:  e_ph[c] = 6'b000010;
      P_CNT:   e_ph[c] = 6'b010010;
      P_SAVE:  e_ph[c] = 6'b001010;
      default: e_ph[c] = {5'b00011, v};
    endcase
    e_res[c] = cur_res;
    e_ovf[c] = cur_ovf;
  endtask

  // Schedule from the stimulus: gate opens on the first tick after CLR, closes GT ticks later,
  // result is the saturated number of edges inside that window, display lasts DT further ticks.
  task automatic build_model();
    int k, t0, tc, td, ne;
    logic go_clr;
    for (int c = 0; c < N; c++) begin e_ph[c] = '0; e_res[c] = 0; e_ovf[c] = 1'b0; end
    cur_res = 0; cur_ovf = 1'b0; k = 0; go_clr = 1'b0;
    while (k < N) begin
      if (!go_clr) begin
        while (k < N && sgl_a[k] && !st_a[k]) begin mark(k, P_IDLE, 1'b0); k++; end
        if (k >= N) break;
        mark(k, P_IDLE, 1'b0);
        k++;
      end
      mark(k, P_CLR, 1'b0);
      t0 = next_tick(k + 1);
      for (int c = k + 1; c <= t0 && c < N; c++) mark(c, P_WAIT, 1'b0);
      tc = t0;
      for (int i = 0; i < GT; i++) tc = next_tick(tc + 1);
      ne = 0;
      for (int c = t0 + 1; c <= tc && c < N; c++) begin mark(c, P_CNT, 1'b0); if (ev(c)) ne++; end
      mark(tc + 1, P_SAVE, 1'b0);
      cur_res = (ne > CMAX) ? CMAX : ne;
      cur_ovf = (ne > CMAX);
      td = tc + 1;
      for (int i = 0; i < DT; i++) td = next_tick(td + 1);
      for (int c = tc + 2; c <= td && c < N; c++) mark(c, P_DISP, c == tc + 2);
      if (td >= N) break;
      go_clr = !sgl_a[td];
      k = td + 1;
    end
  endtask

  task automatic gen(int kind);
    logic s = 1'b0;
    for (int k = 0; k < N; k++) begin
      sgl_a[k] = 1'b0; st_a[k] = 1'b0;
      case (kind)
        0: begin in_a[k] = (k % 12 == 6); sig_a[k] = ((k % 4) >= 2); end
        1: begin in_a[k] = (k % 20 == 10); sig_a[k] = (k < 70) && (k % 2 == 1); end
        2: begin
          in_a[k]  = ($urandom_range(0, 3) == 0);
          sig_a[k] = 1'($urandom_range(0, 1));
          sgl_a[k] = 1'b1;
          st_a[k]  = ($urandom_range(0, 39) == 0);
        end
        3: begin
          if ($urandom_range(0, 29) == 0) s = ~s;
          in_a[k]  = ($urandom_range(0, 2) == 0);
          sig_a[k] = 1'($urandom_range(0, 1));
          sgl_a[k] = s;
          st_a[k]  = ($urandom_range(0, 9) == 0);
        end
        default: begin in_a[k] = (k % 12 == 6); sig_a[k] = (k >= 29 && k < 36); end
      endcase
      if (k == 0) begin in_a[0] = 1'b0; sig_a[0] = 1'b0; end
    end
  endtask

  task automatic sample(string tag, int k);
    o_ph[k]  = {clr, count, save, disp, busy, valid};
    o_res[k] = int'(result);
    o_ovf[k] = ovf;
    chk({tag, "/phase"}, k, 32'(o_ph[k]), 32'(e_ph[k]));
    chk({tag, "/result"}, k, 32'(result), 32'(e_res[k]));
    chk({tag, "/ovf"}, k, 32'(ovf), 32'(e_ovf[k]));
  endtask

  task automatic run_seg(string tag, int abort_at);
    reset = 1'b0; in = 1'b0; sig = 1'b0; single = sgl_a[0]; start = st_a[0];
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "/rst_flags"}, -1, 32'({clr, count, save, disp, busy, valid, ovf}), 32'd0);
    chk({tag, "/rst_result"}, -1, 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    sample(tag, 0);
    for (int k = 1; k < N; k++) begin
      @(posedge clk);
      #1;
      in = in_a[k]; sig = sig_a[k]; single = sgl_a[k]; start = st_a[k];
      @(negedge clk);
      sample(tag, k);
      if (k == abort_at) begin
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "/async_count"}, k, 32'(count), 32'd0);
        chk({tag, "/async_busy"}, k, 32'(busy), 32'd0);
        chk({tag, "/async_result"}, k, 32'(result), 32'd0);
        chk({tag, "/async_ovf"}, k, 32'(ovf), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    int abort_at;

    gen(0); build_model(); run_seg("basic", -1);
    chk("basic/count_start", 7, 32'(o_ph[7][4]), 32'd1);
    chk("basic/wait_tick", 6, 32'(o_ph[6][4]), 32'd0);
    chk("basic/save", 31, 32'(o_ph[31][3]), 32'd1);
    chk("basic/valid", 32, 32'(o_ph[32][0]), 32'd1);
    chk("basic/result6", 32, 32'(o_res[32]), 32'd6);
    chk("basic/result6_next", 80, 32'(o_res[80]), 32'd6);

    gen(1); build_model(); run_seg("ovf", -1);
    chk("ovf/sat_result", 52, 32'(o_res[52]), 32'(CMAX));
    chk("ovf/sat_flag", 52, 32'(o_ovf[52]), 32'd1);
    chk("ovf/zero_result", 132, 32'(o_res[132]), 32'd0);
    chk("ovf/zero_flag", 132, 32'(o_ovf[132]), 32'd0);

    gen(2); build_model(); run_seg("single", -1);
    gen(3); build_model(); run_seg("mixed", -1);

    gen(0); build_model();
    abort_at = -1;
    for (int k = 0; k < N; k++)
      if (e_ph[k] == 6'b010010 && e_res[k] != 0) begin abort_at = k; break; end
    run_seg("abort", abort_at);

    gen(0); build_model(); run_seg("restart", -1);
    chk("restart/clr_first_edge", 1, 32'(o_ph[1][5]), 32'd1);

    gen(4); build_model(); run_seg("sync", -1);
    chk("sync/late_edge", 32, 32'(o_res[32]), (LAT == 0) ? 32'd1 : 32'd0);

    gen(2); build_model(); run_seg("single2", -1);
    gen(3); build_model(); run_seg("mixed2", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
